// File: rtl/flag_cdc_pkg.sv
// Shared constants and helpers for the toggle-based flag crossing.
// Both the destination and the source endpoints import this package.
package flag_cdc_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned PEND_W_DEFAULT  = 4;

  // Action applied to the pending counter in a cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_OVF  = 2'd3
  } cntOp_e;

  function automatic bit syncStagesOk(input int unsigned stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchronizer for a level toggle plus an edge detector.
// One output pulse per settled level change.
module toggle_sync
  import flag_cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clkB,
  input  logic rst,
  input  logic toggle_in,
  output logic edge_out
);

  if (!syncStagesOk(SYNC_STAGES)) begin : gBadStages
    $error("toggle_sync: SYNC_STAGES out of range 2..4");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  always_ff @(posedge clkB or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  // Both operands are flops, so the pulse is glitch-free.
  assign edge_out = sync[SYNC_STAGES-1] ^ hist;

endmodule

// File: rtl/flag_ack_responder.sv
// Receive endpoint of the toggle flag crossing: pulse per event, saturating
// pending counter drained by valid/ready, and an ack toggle per drained event.
module flag_ack_responder
  import flag_cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = PEND_W_DEFAULT
) (
  input  logic              clkB,
  input  logic              rst,
  input  logic              FlagToggle_in,
  output logic              FlagOut_clkB,
  output logic              Valid_clkB,
  input  logic              Ready_clkB,
  output logic [PEND_W-1:0] Pending_clkB,
  output logic              AckToggle_clkB,
  output logic              Overflow_clkB,
  input  logic              ClearOvf_clkB
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic              evtEdge;
  logic              consume;
  logic [PEND_W-1:0] cnt;
  logic              ack;
  logic              ovf;
  cntOp_e            cntOp;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .clkB     (clkB),
    .rst      (rst),
    .toggle_in(FlagToggle_in),
    .edge_out (evtEdge)
  );

  assign Valid_clkB = (cnt != '0);
  assign consume    = Valid_clkB & Ready_clkB;

  // Arrival and drain in the same cycle cancel, so saturation cannot lose it.
  always_comb begin
    cntOp = CNT_HOLD;
    if (evtEdge && !consume) begin
      cntOp = (cnt == CNT_MAX) ? CNT_OVF : CNT_INC;
    end else if (!evtEdge && consume) begin
      cntOp = CNT_DEC;
    end
  end

  always_ff @(posedge clkB or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ack <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (cntOp)
        CNT_INC: cnt <= cnt + 1'b1;
        CNT_DEC: cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ack <= ack ^ consume;
      if (cntOp == CNT_OVF) begin
        ovf <= 1'b1;
      end else if (ClearOvf_clkB) begin
        ovf <= 1'b0;
      end
    end
  end

  assign FlagOut_clkB   = evtEdge;
  assign Pending_clkB   = cnt;
  assign AckToggle_clkB = ack;
  assign Overflow_clkB  = ovf;

endmodule
